// File: rtl/alif_param_serializer_if.sv
// Signal bundle between the host controller and the neuron configuration serializer.
interface alif_param_serializer_if #(
  parameter int FRAME_W = 40
);
  // Handshake: the host's start request is taken on a clock edge only while busy=0.
  // start is not queued while busy=1. done is a one-cycle completion pulse, and
  // busy falls on the same edge. abort drops the transfer without a done pulse.
  logic               start;
  logic               abort;
  logic [FRAME_W-1:0] param_word;
  logic               params_ready;
  logic               load_mode;
  logic               serial_data;
  logic               busy;
  logic               done;
  logic               err;
  logic [1:0]         dbg_state;

  modport master (
    output start, abort, param_word, params_ready,
    input  load_mode, serial_data, busy, done, err, dbg_state
  );

  modport slave (
    input  start, abort, param_word, params_ready,
    output load_mode, serial_data, busy, done, err, dbg_state
  );
endinterface

// File: rtl/alif_param_serializer.sv
// Shifts a parameter frame MSB-first onto load_mode/serial_data, then waits for params_ready.
module alif_param_serializer #(
  parameter int FRAME_W      = 40,
  parameter int CLKS_PER_BIT = 1,
  parameter int TIMEOUT      = 255
) (
  input logic                   clk,
  input logic                   rst_n,
  alif_param_serializer_if.slave bus
);
  localparam int BIT_W = $clog2(FRAME_W + 1);
  localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  LAST_TO  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_RDY = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d, shreg_shift;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               load_mode_q, load_mode_d;
  logic               serial_data_q, serial_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               bit_end, frame_end, to_end;

  assign bit_end     = (cyc_cnt_q == LAST_CYC);
  assign frame_end   = bit_end && (bit_cnt_q == LAST_BIT);
  assign to_end      = (to_cnt_q == LAST_TO);
  assign shreg_shift = shreg_q << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.start) state_d = SHIFT;
      SHIFT: begin
        if (bus.abort)      state_d = IDLE;
        else if (frame_end) state_d = WAIT_RDY;
      end
      WAIT_RDY: if (bus.abort || bus.params_ready || to_end) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    cyc_cnt_d     = cyc_cnt_q;
    to_cnt_d      = to_cnt_q;
    load_mode_d   = load_mode_q;
    serial_data_d = serial_data_q;
    done_d        = 1'b0;
    err_d         = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d       = bus.param_word;
          bit_cnt_d     = '0;
          cyc_cnt_d     = '0;
          to_cnt_d      = '0;
          err_d         = 1'b0;
          load_mode_d   = 1'b1;
          serial_data_d = bus.param_word[FRAME_W-1];
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          load_mode_d   = 1'b0;
          serial_data_d = 1'b0;
        end else if (bit_end) begin
          cyc_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            load_mode_d   = 1'b0;
            serial_data_d = 1'b0;
            to_cnt_d      = '0;
          end else begin
            shreg_d       = shreg_shift;
            bit_cnt_d     = bit_cnt_q + BIT_W'(1);
            serial_data_d = shreg_shift[FRAME_W-1];
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
      end
      WAIT_RDY: begin
        // A ready seen on the expiring edge still counts as success.
        if (!bus.abort) begin
          if (bus.params_ready) begin
            done_d = 1'b1;
          end else if (to_end) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      default: begin
        load_mode_d   = 1'b0;
        serial_data_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      cyc_cnt_q     <= '0;
      to_cnt_q      <= '0;
      load_mode_q   <= 1'b0;
      serial_data_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      cyc_cnt_q     <= cyc_cnt_d;
      to_cnt_q      <= to_cnt_d;
      load_mode_q   <= load_mode_d;
      serial_data_q <= serial_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign bus.load_mode   = load_mode_q;
  assign bus.serial_data = serial_data_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.dbg_state   = state_q;
endmodule
